// File: rtl/dff_meas_sequencer.sv
// dff_meas_sequencer: batches delay-chain measurements and reports floor average, min, max or a timeout error
module dff_meas_sequencer #(
  parameter int CNT_WIDTH        = 8,
  parameter int LOG2_MAX_SAMPLES = 4,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int START_LEN        = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  run,
  input  logic [$clog2(LOG2_MAX_SAMPLES+1)-1:0] cfg_log2_n,
  output logic                                  meas_start,
  input  logic [CNT_WIDTH-1:0]                  measured_cnt,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [CNT_WIDTH-1:0]                  res_avg,
  output logic [CNT_WIDTH-1:0]                  res_min,
  output logic [CNT_WIDTH-1:0]                  res_max,
  output logic                                  res_err,
  output logic                                  busy
);
  localparam int LW = $clog2(LOG2_MAX_SAMPLES + 1);
  localparam int AW = CNT_WIDTH + LOG2_MAX_SAMPLES;
  localparam int SW = LOG2_MAX_SAMPLES + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(START_LEN + 1);

  typedef enum logic [2:0] {IDLE, PULSE, WAIT, ACC, HOLD} state_t;

  state_t               state_q;
  logic [LW-1:0]        n_q, n_clamp;
  logic [AW-1:0]        acc_q, acc_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] smp_q, min_q, max_q, min_d, max_d;
  logic [CNT_WIDTH-1:0] avg_q, rmin_q, rmax_q;
  logic [TW-1:0]        tmo_q;
  logic [PW-1:0]        pls_q;
  logic                 start_q, valid_q, err_q, busy_q, done;

  assign n_clamp = (cfg_log2_n > LW'(LOG2_MAX_SAMPLES)) ? LW'(LOG2_MAX_SAMPLES) : cfg_log2_n;
  assign acc_d   = acc_q + AW'(smp_q);
  assign cnt_d   = cnt_q + SW'(1);
  assign min_d   = (smp_q < min_q) ? smp_q : min_q;
  assign max_d   = (smp_q > max_q) ? smp_q : max_q;
  assign done    = cnt_d == (SW'(1) << n_q);

  assign meas_start = start_q;
  assign res_valid  = valid_q;
  assign res_avg    = avg_q;
  assign res_min    = rmin_q;
  assign res_max    = rmax_q;
  assign res_err    = err_q;
  assign busy       = busy_q;

  // Batch sequencer: pulse, wait for a sample (or time out), accumulate, then hold the result until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      smp_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      avg_q   <= '0;
      rmin_q  <= '0;
      rmax_q  <= '0;
      tmo_q   <= '0;
      pls_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (run) begin
          n_q     <= n_clamp;
          acc_q   <= '0;
          cnt_q   <= '0;
          min_q   <= '1;
          max_q   <= '0;
          err_q   <= 1'b0;
          pls_q   <= '0;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= PULSE;
        end
        PULSE: if (pls_q == PW'(START_LEN - 1)) begin
          start_q <= 1'b0;
          tmo_q   <= '0;
          state_q <= WAIT;
        end else begin
          pls_q <= pls_q + PW'(1);
        end
        WAIT: if (tmo_q != '0 && measured_cnt != '0) begin
          smp_q   <= measured_cnt;
          state_q <= ACC;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_q   <= 1'b1;
          valid_q <= 1'b1;
          avg_q   <= '0;
          rmin_q  <= '0;
          rmax_q  <= '0;
          state_q <= HOLD;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
        ACC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          min_q <= min_d;
          max_q <= max_d;
          if (done) begin
            valid_q <= 1'b1;
            avg_q   <= CNT_WIDTH'(acc_d >> n_q);
            rmin_q  <= min_d;
            rmax_q  <= max_d;
            state_q <= HOLD;
          end else begin
            pls_q   <= '0;
            start_q <= 1'b1;
            state_q <= PULSE;
          end
        end
        HOLD: if (res_ready) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
          avg_q   <= '0;
          rmin_q  <= '0;
          rmax_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dff_meas_sequencer.sv
// tb_dff_meas_sequencer: directed and randomized batches checked against a sum/min/max reference model
module tb_dff_meas_sequencer;
  localparam int CW = 8, LM = 4, TO = 255, SL = 2;

  logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0, res_ready = 1'b0;
  logic [2:0]    cfg_log2_n = '0;
  logic [CW-1:0] measured_cnt = '0;
  logic          meas_start, res_valid, res_err, busy;
  logic [CW-1:0] res_avg, res_min, res_max;
  int            n_cmp = 0, n_err = 0;
  int            smp[16], dly[16];

  dff_meas_sequencer #(.CNT_WIDTH(CW), .LOG2_MAX_SAMPLES(LM), .TIMEOUT_CYCLES(TO), .START_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cfg_log2_n(cfg_log2_n), .meas_start(meas_start),
    .measured_cnt(measured_cnt), .res_valid(res_valid), .res_ready(res_ready), .res_avg(res_avg),
    .res_min(res_min), .res_max(res_max), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    measured_cnt = '0;
    for (int j = 0; j < SL; j++) begin
      chk("start_high", meas_start, 1);
      tick();
    end
    chk("start_low", meas_start, 0);
  endtask

  task automatic check_result(input int avg, input int mn, input int mx, input int err, input int hold);
    for (int h = 0; h <= hold; h++) begin
      chk("valid", res_valid, 1);
      chk("avg", res_avg, avg);
      chk("min", res_min, mn);
      chk("max", res_max, mx);
      chk("err", res_err, err);
      chk("busy_hold", busy, 1);
      chk("start_hold", meas_start, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("valid_drop", res_valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  task automatic batch(input logic [2:0] cfg, input int hold);
    int n, cnt, sum, mn, mx;
    n   = (cfg > 3'(LM)) ? LM : int'(cfg);
    cnt = 1 << n;
    sum = 0; mn = 255; mx = 0;
    for (int i = 0; i < cnt; i++) begin
      sum += smp[i];
      mn = (smp[i] < mn) ? smp[i] : mn;
      mx = (smp[i] > mx) ? smp[i] : mx;
    end
    cfg_log2_n = cfg;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("busy_launch", busy, 1);
    for (int i = 0; i < cnt; i++) begin
      pulse();
      for (int d = 0; d < dly[i]; d++) tick();
      measured_cnt = CW'(smp[i]);
      if (dly[i] == 0) tick();
      tick();
      chk("acc_quiet", {meas_start, res_valid}, 0);
      tick();
      if (i < cnt - 1) chk("next_pulse", meas_start, 1);
    end
    measured_cnt = '0;
    check_result(sum >> n, mn, mx, 0, hold);
  endtask

  initial begin
    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_start", meas_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {res_avg, res_min, res_max, res_err}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", busy, 0);

    smp[0] = 37; dly[0] = 3;
    batch(3'd0, 0);

    smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 41;
    dly[0] = 1; dly[1] = 2; dly[2] = 0; dly[3] = 4;
    batch(3'd2, 20);

    smp[0] = 50; smp[1] = 50; dly[0] = 2; dly[1] = 1;
    batch(3'd1, 1);

    for (int i = 0; i < 16; i++) begin smp[i] = 255; dly[i] = i % 3; end
    batch(3'd7, 0);

    begin : timeout_case
      int pulses;
      pulses = 0;
      cfg_log2_n = 3'd1;
      run = 1'b1;
      tick();
      run = 1'b0;
      pulse();
      for (int c = 0; c < TO - 1; c++) begin
        tick();
        if (meas_start) pulses++;
      end
      chk("tmo_early", res_valid, 0);
      tick();
      chk("tmo_extra_pulses", pulses, 0);
      check_result(0, 0, 0, 1, 2);
    end

    begin : reset_case
      cfg_log2_n = 3'd2;
      run = 1'b1;
      tick();
      run = 1'b0;
      pulse();
      tick();
      measured_cnt = 8'd100;
      tick();
      tick();
      chk("second_pulse", meas_start, 1);
      measured_cnt = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_start", meas_start, 0);
      chk("arst_busy", busy, 0);
      chk("arst_valid", res_valid, 0);
      chk("arst_outs", {res_avg, res_min, res_max, res_err}, 0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (c % 5 == 4) chk("post_rst_quiet", {res_valid, busy, meas_start}, 0);
      end
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        smp[i] = int'($urandom_range(1, 255));
        dly[i] = int'($urandom_range(0, 4));
      end
      batch(3'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
